// File: rtl/k007452_pkg.sv
// Shared definitions for the K007452 math-chip host sequencer: FSM states, op encoding,
// register map, access counts and the per-access address/data selection helpers.
package k007452_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WAIT,
        ST_READ,
        ST_RESP
    } state_e;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_e;

    localparam logic [2:0] REG_MUL_LO   = 3'd0;
    localparam logic [2:0] REG_MUL_HI   = 3'd1;
    localparam logic [2:0] REG_DIV_B_LO = 3'd2;
    localparam logic [2:0] REG_DIV_B_HI = 3'd3;
    localparam logic [2:0] REG_DIV_HI   = 3'd4;
    localparam logic [2:0] REG_DIV_LO   = 3'd5;

    localparam int MUL_NWR = 2;
    localparam int MUL_NRD = 2;
    localparam int DIV_NWR = 4;
    localparam int DIV_NRD = 4;

    function automatic logic [1:0] last_wr_idx(input op_e op);
        return (op == OP_MUL) ? 2'(MUL_NWR - 1) : 2'(DIV_NWR - 1);
    endfunction

    function automatic logic [1:0] last_rd_idx(input op_e op);
        return (op == OP_MUL) ? 2'(MUL_NRD - 1) : 2'(DIV_NRD - 1);
    endfunction

    // Divide loads the divisor first so the final write (dividend low byte) triggers the op.
    function automatic logic [2:0] wr_addr(input op_e op, input logic [1:0] idx);
        if (op == OP_MUL) begin
            return (idx == 2'd0) ? REG_MUL_LO : REG_MUL_HI;
        end
        case (idx)
            2'd0:    return REG_DIV_B_LO;
            2'd1:    return REG_DIV_B_HI;
            2'd2:    return REG_DIV_HI;
            default: return REG_DIV_LO;
        endcase
    endfunction

    function automatic logic [7:0] wr_data(input op_e op, input logic [1:0] idx,
                                           input logic [15:0] a, input logic [15:0] b);
        if (op == OP_MUL) begin
            return (idx == 2'd0) ? a[7:0] : b[7:0];
        end
        case (idx)
            2'd0:    return b[7:0];
            2'd1:    return b[15:8];
            2'd2:    return a[15:8];
            default: return a[7:0];
        endcase
    endfunction

    function automatic logic [2:0] rd_addr(input op_e op, input logic [1:0] idx);
        return (op == OP_MUL) ? {1'b0, idx} : REG_DIV_B_LO + {1'b0, idx};
    endfunction

endpackage

// File: rtl/k007452_bus_cyc.sv
// One K007452 bus access: holds address/data for CYC clocks, drives the strobe low for the
// first CYC-1 of them, pulses sample on the last low clock of a read and done on the final clock.
module k007452_bus_cyc #(
    parameter int CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       is_read,
    input  logic [2:0] addr,
    input  logic [7:0] data,
    output logic [2:0] ab,
    output logic [7:0] db_o,
    output logic       db_en,
    output logic       wr_n,
    output logic       rd_n,
    output logic       sample,
    output logic       done
);

    localparam logic [3:0] LAST_CNT   = 4'(CYC - 1);
    localparam logic [3:0] SAMPLE_CNT = 4'(CYC - 2);

    logic       busy_q, busy_d;
    logic [3:0] cnt_q, cnt_d;
    logic       rd_q, rd_d;
    logic [2:0] ab_q, ab_d;
    logic [7:0] db_q, db_d;
    logic       strobe_low;

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        rd_d   = rd_q;
        ab_d   = ab_q;
        db_d   = db_q;
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = 4'd0;
            rd_d   = is_read;
            ab_d   = addr;
            db_d   = is_read ? 8'h00 : data;
        end else if (done) begin
            busy_d = 1'b0;
            cnt_d  = 4'd0;
        end else if (busy_q) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Strobes derive from reset-cleared flops so an async reset releases them immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= 4'd0;
            rd_q   <= 1'b0;
            ab_q   <= 3'd0;
            db_q   <= 8'h00;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            rd_q   <= rd_d;
            ab_q   <= ab_d;
            db_q   <= db_d;
        end
    end

    assign strobe_low = busy_q && (cnt_q != LAST_CNT);
    assign done       = busy_q && (cnt_q == LAST_CNT);
    assign sample     = busy_q && rd_q && (cnt_q == SAMPLE_CNT);
    assign wr_n       = ~(strobe_low && !rd_q);
    assign rd_n       = ~(strobe_low && rd_q);
    assign db_en      = strobe_low && !rd_q;
    assign ab         = ab_q;
    assign db_o       = db_q;

endmodule

// File: rtl/k007452_host_seq.sv
// Host-side sequencer that runs multiply/divide commands through the K007452 register bus.
// Optional macro K007452_HOST_DIVZERO_EN short-circuits divide-by-zero with an error response.
module k007452_host_seq
    import k007452_pkg::*;
#(
    parameter int CYC      = 2,
    parameter int MUL_WAIT = 8,
    parameter int DIV_WAIT = 40
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        CMD_OP,
    input  logic [15:0] CMD_A,
    input  logic [15:0] CMD_B,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [15:0] RSP_Q,
    output logic [15:0] RSP_R,
    output logic        RSP_ERR,
    output logic [2:0]  AB,
    output logic [7:0]  DB_O,
    input  logic [7:0]  DB_I,
    output logic        DB_EN,
    output logic        WR,
    output logic        RD
);

    localparam logic [7:0] MUL_WAIT_LEN = 8'(MUL_WAIT);
    localparam logic [7:0] DIV_WAIT_LEN = 8'(DIV_WAIT);

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] quo_q, quo_d;
    logic [15:0] rem_q, rem_d;

    logic       bus_start;
    logic       bus_rd;
    logic [2:0] bus_addr;
    logic [7:0] bus_data;
    logic       bus_sample;
    logic       bus_done;
    logic [7:0] wait_len;
    logic [1:0] idx_next;
    logic       div_zero;

    assign wait_len = (op_q == OP_MUL) ? MUL_WAIT_LEN : DIV_WAIT_LEN;
    assign idx_next = idx_q + 2'd1;

`ifdef K007452_HOST_DIVZERO_EN
    logic err_q, err_d;

    assign div_zero = CMD_OP && (CMD_B == 16'h0000);

    always_comb begin
        err_d = err_q;
        if (state_q == ST_IDLE && CMD_VALID) begin
            err_d = div_zero;
        end
    end

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign RSP_ERR = err_q;
`else
    assign div_zero = 1'b0;
    assign RSP_ERR  = 1'b0;
`endif

    // Each access's successor is started on its done clock so accesses run back to back.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        idx_d      = idx_q;
        wait_cnt_d = wait_cnt_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        bus_start  = 1'b0;
        bus_rd     = 1'b0;
        bus_addr   = wr_addr(op_q, idx_q);
        bus_data   = wr_data(op_q, idx_q, a_q, b_q);

        case (state_q)
            ST_IDLE: begin
                if (CMD_VALID) begin
                    op_d  = op_e'(CMD_OP);
                    a_d   = CMD_A;
                    b_d   = CMD_B;
                    idx_d = 2'd0;
                    quo_d = 16'h0000;
                    rem_d = 16'h0000;
                    if (div_zero) begin
                        state_d = ST_RESP;
                        quo_d   = 16'hFFFF;
                        rem_d   = CMD_A;
                    end else begin
                        state_d   = ST_WRITE;
                        bus_start = 1'b1;
                        bus_addr  = wr_addr(op_e'(CMD_OP), 2'd0);
                        bus_data  = wr_data(op_e'(CMD_OP), 2'd0, CMD_A, CMD_B);
                    end
                end
            end
            ST_WRITE: begin
                if (bus_done) begin
                    if (idx_q == last_wr_idx(op_q)) begin
                        idx_d = 2'd0;
                        if (wait_len == 8'd0) begin
                            state_d   = ST_READ;
                            bus_start = 1'b1;
                            bus_rd    = 1'b1;
                            bus_addr  = rd_addr(op_q, 2'd0);
                        end else begin
                            state_d    = ST_WAIT;
                            wait_cnt_d = 8'd0;
                        end
                    end else begin
                        idx_d     = idx_next;
                        bus_start = 1'b1;
                        bus_addr  = wr_addr(op_q, idx_next);
                        bus_data  = wr_data(op_q, idx_next, a_q, b_q);
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q >= wait_len - 8'd1) begin
                    state_d   = ST_READ;
                    idx_d     = 2'd0;
                    bus_start = 1'b1;
                    bus_rd    = 1'b1;
                    bus_addr  = rd_addr(op_q, 2'd0);
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ST_READ: begin
                if (bus_sample) begin
                    case (idx_q)
                        2'd0:    quo_d[7:0]  = DB_I;
                        2'd1:    quo_d[15:8] = DB_I;
                        2'd2:    rem_d[7:0]  = DB_I;
                        default: rem_d[15:8] = DB_I;
                    endcase
                end
                if (bus_done) begin
                    if (idx_q == last_rd_idx(op_q)) begin
                        state_d = ST_RESP;
                    end else begin
                        idx_d     = idx_next;
                        bus_start = 1'b1;
                        bus_rd    = 1'b1;
                        bus_addr  = rd_addr(op_q, idx_next);
                    end
                end
            end
            ST_RESP: begin
                if (RSP_READY) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_MUL;
            a_q        <= 16'h0000;
            b_q        <= 16'h0000;
            idx_q      <= 2'd0;
            wait_cnt_q <= 8'd0;
            quo_q      <= 16'h0000;
            rem_q      <= 16'h0000;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            idx_q      <= idx_d;
            wait_cnt_q <= wait_cnt_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
        end
    end

    k007452_bus_cyc #(
        .CYC(CYC)
    ) u_bus_cyc (
        .clk    (CLK),
        .rst_n  (RES),
        .start  (bus_start),
        .is_read(bus_rd),
        .addr   (bus_addr),
        .data   (bus_data),
        .ab     (AB),
        .db_o   (DB_O),
        .db_en  (DB_EN),
        .wr_n   (WR),
        .rd_n   (RD),
        .sample (bus_sample),
        .done   (bus_done)
    );

    assign CMD_READY = (state_q == ST_IDLE);
    assign RSP_VALID = (state_q == ST_RESP);
    assign RSP_Q     = quo_q;
    assign RSP_R     = rem_q;

endmodule

// File: tb/tb_k007452_host_seq.sv
// Directed bench for k007452_host_seq: default instance plus a CYC=3 / MUL_WAIT=0 instance,
// with a simple register-file bus model and strobe monitors.
module tb_k007452_host_seq;

    logic        CLK = 1'b0;
    logic        RES = 1'b0;

    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_op = 1'b0;
    logic [15:0] cmd_a = 16'h0;
    logic [15:0] cmd_b = 16'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_q;
    logic [15:0] rsp_r;
    logic        rsp_err;
    logic [2:0]  ab;
    logic [7:0]  db_o;
    logic [7:0]  db_i;
    logic        db_en;
    logic        wr_n;
    logic        rd_n;

    logic        c3_valid = 1'b0;
    logic        c3_ready;
    logic        c3_op = 1'b0;
    logic [15:0] c3_a = 16'h0;
    logic [15:0] c3_b = 16'h0;
    logic        c3_rsp_valid;
    logic [15:0] c3_q;
    logic [15:0] c3_r;
    logic        c3_err;
    logic [2:0]  c3_ab;
    logic [7:0]  c3_db_o;
    logic [7:0]  c3_db_i;
    logic        c3_db_en;
    logic        c3_wr_n;
    logic        c3_rd_n;

    logic [7:0]  rdmem [0:7];

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [2:0] wlog_addr [0:63];
    logic [7:0] wlog_data [0:63];
    logic [2:0] rlog_addr [0:63];
    int wlog_n = 0;
    int rlog_n = 0;
    logic prev_wr = 1'b1;
    logic prev_rd = 1'b1;
    int wr_run = 0;
    int rd_run = 0;
    int overlap_err = 0;
    int en_err = 0;
    int stab_err = 0;
    int run_err = 0;

    logic prev3_wr = 1'b1;
    logic prev3_rd = 1'b1;
    int run3 = 0;
    int run3_err = 0;
    int run3_total = 0;
    int overlap3_err = 0;

    always #5 CLK = ~CLK;

    assign db_i    = !rd_n    ? rdmem[ab]    : 8'h00;
    assign c3_db_i = !c3_rd_n ? rdmem[c3_ab] : 8'h00;

    k007452_host_seq dut (
        .CLK(CLK), .RES(RES),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_OP(cmd_op),
        .CMD_A(cmd_a), .CMD_B(cmd_b),
        .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_Q(rsp_q), .RSP_R(rsp_r),
        .RSP_ERR(rsp_err),
        .AB(ab), .DB_O(db_o), .DB_I(db_i), .DB_EN(db_en), .WR(wr_n), .RD(rd_n)
    );

    k007452_host_seq #(.CYC(3), .MUL_WAIT(0), .DIV_WAIT(40)) dut3 (
        .CLK(CLK), .RES(RES),
        .CMD_VALID(c3_valid), .CMD_READY(c3_ready), .CMD_OP(c3_op),
        .CMD_A(c3_a), .CMD_B(c3_b),
        .RSP_VALID(c3_rsp_valid), .RSP_READY(1'b1), .RSP_Q(c3_q), .RSP_R(c3_r),
        .RSP_ERR(c3_err),
        .AB(c3_ab), .DB_O(c3_db_o), .DB_I(c3_db_i), .DB_EN(c3_db_en), .WR(c3_wr_n), .RD(c3_rd_n)
    );

    // Bus monitor for the default instance: logs accesses and tallies protocol violations.
    always @(posedge CLK) begin
        if (!RES) begin
            prev_wr <= 1'b1;
            prev_rd <= 1'b1;
        end else begin
            if (!wr_n && !rd_n) overlap_err <= overlap_err + 1;
            if (db_en !== !wr_n) en_err <= en_err + 1;
            if (!wr_n) begin
                if (prev_wr) begin
                    wlog_addr[wlog_n % 64] <= ab;
                    wlog_data[wlog_n % 64] <= db_o;
                    wlog_n <= wlog_n + 1;
                    wr_run <= 1;
                end else begin
                    wr_run <= wr_run + 1;
                    if (ab !== wlog_addr[(wlog_n - 1) % 64] || db_o !== wlog_data[(wlog_n - 1) % 64])
                        stab_err <= stab_err + 1;
                end
            end else if (!prev_wr && wr_run != 1) begin
                run_err <= run_err + 1;
            end
            if (!rd_n) begin
                if (prev_rd) begin
                    rlog_addr[rlog_n % 64] <= ab;
                    rlog_n <= rlog_n + 1;
                    rd_run <= 1;
                end else begin
                    rd_run <= rd_run + 1;
                end
            end else if (!prev_rd && rd_run != 1) begin
                run_err <= run_err + 1;
            end
            prev_wr <= wr_n;
            prev_rd <= rd_n;
        end
    end

    // Strobe monitor for the CYC=3 instance: every low run must be two clocks.
    always @(posedge CLK) begin
        if (!RES) begin
            prev3_wr <= 1'b1;
            prev3_rd <= 1'b1;
        end else begin
            if (!c3_wr_n && !c3_rd_n) overlap3_err <= overlap3_err + 1;
            if (!c3_wr_n || !c3_rd_n) begin
                run3 <= (prev3_wr && prev3_rd) ? 1 : run3 + 1;
            end else if (!prev3_wr || !prev3_rd) begin
                run3_total <= run3_total + 1;
                if (run3 != 2) run3_err <= run3_err + 1;
            end
            prev3_wr <= c3_wr_n;
            prev3_rd <= c3_rd_n;
        end
    end

    task automatic check(input string tag, input logic [47:0] observed, input logic [47:0] expected);
        total_cnt++;
        assert (observed === expected) pass_cnt++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 300) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_cmd(input logic op, input logic [15:0] a, input logic [15:0] b, output int lat);
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        wait_rsp(lat);
    endtask

    initial begin
        int lat;
        int wbase;
        int rbase;
        int n;
        int seen;

        repeat (3) tick();
        check("rst_cmd_ready", 48'(cmd_ready), 48'd1);
        check("rst_rsp_valid", 48'(rsp_valid), 48'd0);
        check("rst_rsp_qr_err", 48'({rsp_q, rsp_r, rsp_err}), 48'd0);
        check("rst_bus", 48'({ab, db_o, db_en, wr_n, rd_n}), 48'({3'd0, 8'h00, 1'b0, 1'b1, 1'b1}));
        RES = 1'b1;
        repeat (2) tick();

        // Multiply 0x12 * 0x34 = 0x03A8
        rdmem[0] = 8'hA8; rdmem[1] = 8'h03;
        wbase = wlog_n; rbase = rlog_n;
        run_cmd(1'b0, 16'h0012, 16'h0034, lat);
        check("mul_latency", 48'(lat), 48'd17);
        check("mul_q", 48'(rsp_q), 48'h03A8);
        check("mul_r_err", 48'({rsp_r, rsp_err}), 48'd0);
        check("mul_nwr_nrd", 48'({16'(wlog_n - wbase), 16'(rlog_n - rbase)}), 48'({16'd2, 16'd2}));
        check("mul_writes", 48'({wlog_addr[wbase], wlog_data[wbase], wlog_addr[wbase + 1], wlog_data[wbase + 1]}),
              48'({3'd0, 8'h12, 3'd1, 8'h34}));
        check("mul_reads", 48'({rlog_addr[rbase], rlog_addr[rbase + 1]}), 48'({3'd0, 3'd1}));
        tick();
        check("mul_back_idle", 48'({cmd_ready, rsp_valid}), 48'b10);

        // Divide 1000 / 7 = 142 r 6
        rdmem[2] = 8'h8E; rdmem[3] = 8'h00; rdmem[4] = 8'h06; rdmem[5] = 8'h00;
        wbase = wlog_n; rbase = rlog_n;
        run_cmd(1'b1, 16'd1000, 16'd7, lat);
        check("div_latency", 48'(lat), 48'd57);
        check("div_q_r", 48'({rsp_q, rsp_r, rsp_err}), 48'({16'h008E, 16'h0006, 1'b0}));
        check("div_nwr_nrd", 48'({16'(wlog_n - wbase), 16'(rlog_n - rbase)}), 48'({16'd4, 16'd4}));
        check("div_writes_01", 48'({wlog_addr[wbase], wlog_data[wbase], wlog_addr[wbase + 1], wlog_data[wbase + 1]}),
              48'({3'd2, 8'h07, 3'd3, 8'h00}));
        check("div_writes_23", 48'({wlog_addr[wbase + 2], wlog_data[wbase + 2], wlog_addr[wbase + 3], wlog_data[wbase + 3]}),
              48'({3'd4, 8'h03, 3'd5, 8'hE8}));
        check("div_reads", 48'({rlog_addr[rbase], rlog_addr[rbase + 1], rlog_addr[rbase + 2], rlog_addr[rbase + 3]}),
              48'({3'd2, 3'd3, 3'd4, 3'd5}));
        tick();

        // Response held with RSP_READY low while a new command is offered
        rsp_ready = 1'b0;
        rdmem[0] = 8'h1E; rdmem[1] = 8'h00;
        run_cmd(1'b0, 16'h0005, 16'h0006, lat);
        check("hold_latency", 48'(lat), 48'd17);
        cmd_op = 1'b0; cmd_a = 16'h0010; cmd_b = 16'h0010; cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("hold_cyc%0d", i), 48'({rsp_valid, cmd_ready, rsp_q, rsp_r}),
                  48'({1'b1, 1'b0, 16'h001E, 16'h0000}));
            tick();
        end
        rdmem[0] = 8'h00; rdmem[1] = 8'h01;
        rsp_ready = 1'b1;
        tick();
        check("hold_handshake_idle", 48'({cmd_ready, rsp_valid}), 48'b10);
        tick();
        cmd_valid = 1'b0;
        check("hold_next_accepted", 48'(cmd_ready), 48'd0);
        wait_rsp(lat);
        check("hold_next_latency", 48'(lat), 48'd17);
        check("hold_next_q", 48'(rsp_q), 48'h0100);
        tick();

        // Reset pulsed during the third divide write
        cmd_op = 1'b1; cmd_a = 16'd1000; cmd_b = 16'd7; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (!(wr_n === 1'b0 && ab === 3'd4) && n < 50) begin
            tick();
            n++;
        end
        check("rst_mid_reached", 48'({wr_n, ab}), 48'({1'b0, 3'd4}));
        RES = 1'b0;
        #1;
        check("rst_mid_strobes", 48'({wr_n, db_en, rd_n}), 48'b101);
        check("rst_mid_ready", 48'(cmd_ready), 48'd1);
        tick();
        tick();
        RES = 1'b1;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            if (rsp_valid === 1'b1) seen++;
            tick();
        end
        check("rst_mid_no_rsp", 48'(seen), 48'd0);
        check("rst_mid_ready_after", 48'(cmd_ready), 48'd1);

        // Divide with zero divisor
        wbase = wlog_n; rbase = rlog_n;
`ifdef K007452_HOST_DIVZERO_EN
        run_cmd(1'b1, 16'h1234, 16'h0000, lat);
        check("dz_latency", 48'(lat), 48'd1);
        check("dz_q_r_err", 48'({rsp_q, rsp_r, rsp_err}), 48'({16'hFFFF, 16'h1234, 1'b1}));
        check("dz_no_bus", 48'({16'(wlog_n - wbase), 16'(rlog_n - rbase)}), 48'd0);
`else
        rdmem[2] = 8'hFF; rdmem[3] = 8'hFF; rdmem[4] = 8'h34; rdmem[5] = 8'h12;
        run_cmd(1'b1, 16'h1234, 16'h0000, lat);
        check("dz_latency", 48'(lat), 48'd57);
        check("dz_q_r_err", 48'({rsp_q, rsp_r, rsp_err}), 48'({16'hFFFF, 16'h1234, 1'b0}));
        check("dz_bus", 48'({16'(wlog_n - wbase), 16'(rlog_n - rbase)}), 48'({16'd4, 16'd4}));
`endif
        tick();

        // CYC=3, MUL_WAIT=0 instance: 0x0F * 0x0F = 0x00E1
        rdmem[0] = 8'hE1; rdmem[1] = 8'h00;
        c3_op = 1'b0; c3_a = 16'h000F; c3_b = 16'h000F; c3_valid = 1'b1;
        tick();
        c3_valid = 1'b0;
        lat = 1;
        while (c3_rsp_valid !== 1'b1 && lat < 300) begin
            tick();
            lat++;
        end
        check("c3_latency", 48'(lat), 48'd13);
        check("c3_q_r", 48'({c3_q, c3_r}), 48'({16'h00E1, 16'h0000}));
        check("c3_runs", 48'({16'(run3_total), 16'(run3_err), 16'(overlap3_err)}), 48'({16'd4, 16'd0, 16'd0}));

        check("bus_overlap", 48'(overlap_err), 48'd0);
        check("bus_db_en", 48'(en_err), 48'd0);
        check("bus_stable", 48'(stab_err), 48'd0);
        check("bus_strobe_len", 48'(run_err), 48'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/k007452_host_seq.md
K007452_HOST_SEQ -- requirements
Module: k007452_host_seq

Interface
REQ-001 SHALL have parameter CYC, default 2, giving bus-cycle length in clocks (legal range 2..15).
REQ-002 SHALL have parameter MUL_WAIT, default 8, giving idle clocks between the last multiply write and the first read (legal range 0..255).
REQ-003 SHALL have parameter DIV_WAIT, default 40, giving idle clocks between the last divide write and the first read (legal range 0..255).
REQ-004 SHALL have ports CLK in 1, single clock; RES in 1, asynchronous active-low reset.
REQ-005 SHALL have ports CMD_VALID in 1, command offered; CMD_READY out 1, command accepted when high with CMD_VALID.
REQ-006 SHALL have ports CMD_OP in 1 (0 = multiply, 1 = divide); CMD_A in 16 (multiplicand in [7:0], or dividend); CMD_B in 16 (multiplier in [7:0], or divisor).
REQ-007 SHALL have ports RSP_VALID out 1; RSP_READY in 1; RSP_Q out 16 (product or quotient); RSP_R out 16 (remainder, 0 for multiply); RSP_ERR out 1.
REQ-008 SHALL have ports AB out 3 (math register address); DB_O out 8 (write data); DB_I in 8 (read data); DB_EN out 1 (drive DB_O onto the bus); WR out 1 (active-low write strobe); RD out 1 (active-low read strobe).

Function
REQ-009 SHALL implement FSM states IDLE, WRITE, WAIT, READ and RESP; CMD_READY SHALL be high only in IDLE.
REQ-010 On CMD_VALID and CMD_READY, SHALL latch CMD_OP, CMD_A and CMD_B, and SHALL enter WRITE on the next clock.
REQ-011 Each bus access SHALL last CYC clocks: the strobe low for CYC-1 clocks, then high for 1 clock; AB and DB_O SHALL be stable for the whole access.
REQ-012 Multiply writes SHALL be, in order: reg0 <- A[7:0], then reg1 <- B[7:0] (the reg1 write starts the multiply).
REQ-013 Divide writes SHALL be, in order: reg2 <- B[7:0], reg3 <- B[15:8], reg4 <- A[15:8], then reg5 <- A[7:0] (the reg5 write starts the divide).
REQ-014 DB_EN SHALL be high exactly while WR is low.
REQ-015 WAIT SHALL last MUL_WAIT or DIV_WAIT clocks, according to the latched op; a value of 0 SHALL skip WAIT.
REQ-016 Multiply reads SHALL be reg0 -> Q[7:0], then reg1 -> Q[15:8].
REQ-017 Divide reads SHALL be reg2 -> Q[7:0], reg3 -> Q[15:8], reg4 -> R[7:0], then reg5 -> R[15:8].
REQ-018 DB_I SHALL be sampled on the last strobe-low clock of each read.
REQ-019 RSP_VALID SHALL rise exactly 1 + Nwr*CYC + WAIT + Nrd*CYC clocks after the accept edge.
REQ-020 RSP_Q, RSP_R and RSP_ERR SHALL remain stable while RSP_VALID is high and RSP_READY is low.
REQ-021 A clock with RSP_VALID and RSP_READY both high SHALL return the FSM to IDLE; the next command SHALL not be accepted before the following clock.
REQ-022 WR and RD SHALL never be low in the same clock.
REQ-023 Both strobes SHALL be high in IDLE, WAIT and RESP.
REQ-024 CMD_* inputs SHALL be ignored outside IDLE.
REQ-025 A WAIT counter at terminal count SHALL not wrap.
REQ-026 The access index SHALL not pass the last access of the current op.

Reset
REQ-027 While RES is low, SHALL hold state IDLE, CMD_READY=1, RSP_VALID=0, RSP_Q=0, RSP_R=0, RSP_ERR=0, AB=0, DB_O=0, DB_EN=0, WR=1 and RD=1.
REQ-028 RES asserted mid-access SHALL abort immediately (strobes high asynchronously); no partial response SHALL be produced.

Configuration
REQ-029 SHALL honour macro K007452_HOST_DIVZERO_EN.
REQ-030 With K007452_HOST_DIVZERO_EN defined, a divide with B=0 SHALL go IDLE->RESP with no bus cycles, RSP_Q=16'hFFFF, RSP_R=A and RSP_ERR=1, RSP_VALID rising 1 clock after accept.
REQ-031 Without K007452_HOST_DIVZERO_EN, B=0 SHALL be handled as a normal divide, and RSP_ERR SHALL be tied 0.

Structure
REQ-032 Shared package k007452_pkg SHALL hold the FSM state enum, op encoding, register addresses REG_MUL_LO=0 .. REG_DIV_LO=5, and access-count constants (mul: 2 writes/2 reads; div: 4 writes/4 reads).
REQ-033 The bus-cycle timer and strobe generator SHALL be one sub-module, k007452_bus_cyc (start, is_read, addr, data -> strobes, sample pulse, done).

Verification
REQ-034 Reset release, then multiply A=0x0012, B=0x0034 with the bus model returning the product -> bus trace W0=12, W1=34, R0, R1; RSP_Q=0x03A8, RSP_R=0; RSP_VALID at accept+17 clocks (defaults).
REQ-035 Divide A=1000, B=7 -> writes 2:07, 3:00, 4:03, 5:E8; RSP_Q=0x008E, RSP_R=0x0006; RSP_VALID at accept+57 clocks.
REQ-036 RSP_READY held low for 10 clocks -> outputs frozen, CMD_READY=0; a new CMD_VALID is not accepted until 1 clock after the handshake.
REQ-037 RES pulsed low during the third divide write -> WR=1 and DB_EN=0 at once, RSP_VALID never rises, CMD_READY=1 after release.
REQ-038 With K007452_HOST_DIVZERO_EN, divide A=0x1234, B=0 -> no strobes, RSP_Q=0xFFFF, RSP_R=0x1234, RSP_ERR=1 at accept+1.
REQ-039 With CYC=3 and MUL_WAIT=0 -> each strobe low 2 clocks; multiply latency 13 clocks; WR and RD are never low together.
